// File: rtl/icache_controller_pkg.sv
// Shared types and field positions for the direct-mapped instruction cache.
package icache_controller_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    MEM_READ = 2'd1,
    UPDATE   = 2'd2
  } state_t;

  localparam int unsigned WORD_W     = 32;
  localparam int unsigned BLOCK_W    = 128;
  localparam int unsigned OFFSET_LSB = 2;
  localparam int unsigned OFFSET_W   = 2;
  localparam int unsigned INDEX_LSB  = 4;
  localparam int unsigned COUNT_W    = 16;

  // Word k of a block occupies bits [32k+31:32k].
  function automatic logic [WORD_W-1:0] select_word(input logic [BLOCK_W-1:0] blk,
                                                    input logic [OFFSET_W-1:0] off);
    return blk[WORD_W*off +: WORD_W];
  endfunction

endpackage

// File: rtl/icache_controller_if.sv
// CPU fetch and instruction-memory signals seen by the cache.
interface icache_controller_if #(
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned MEM_ADDR_W = 28
);
  logic                  cpu_read;
  logic [ADDR_W-1:0]     cpu_address;
  logic [31:0]           cpu_instruction;
  logic                  cpu_busywait;
  logic                  mem_read;
  logic [MEM_ADDR_W-1:0] mem_address;
  logic [127:0]          mem_readdata;
  logic                  mem_busywait;

  // Cache side.
  modport slave (
    input  cpu_read, cpu_address, mem_readdata, mem_busywait,
    output cpu_instruction, cpu_busywait, mem_read, mem_address
  );

  // CPU / memory side.
  modport master (
    output cpu_read, cpu_address, mem_readdata, mem_busywait,
    input  cpu_instruction, cpu_busywait, mem_read, mem_address
  );
endinterface

// File: rtl/icache_controller_block_store.sv
// Valid/tag/data storage with one fill write port and a combinational lookup.
module icache_block_store
  import icache_controller_pkg::*;
#(
  parameter int unsigned INDEX_W = 3,
  parameter int unsigned TAG_W   = 25
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic [INDEX_W-1:0]   rd_index,
  input  logic [TAG_W-1:0]     rd_tag,
  input  logic [OFFSET_W-1:0]  rd_offset,
  output logic                 rd_match,
  output logic [WORD_W-1:0]    rd_word,
  input  logic                 wr_en,
  input  logic [INDEX_W-1:0]   wr_index,
  input  logic [TAG_W-1:0]     wr_tag,
  input  logic [BLOCK_W-1:0]   wr_data
);
  localparam int unsigned NUM_SETS = 2 ** INDEX_W;

  logic [NUM_SETS-1:0] valid;
  logic [TAG_W-1:0]    tag_array  [NUM_SETS];
  logic [BLOCK_W-1:0]  data_array [NUM_SETS];

  // Valid bits clear on reset and are set when a line is installed.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      valid <= '0;
    end else if (wr_en) begin
      valid[wr_index] <= 1'b1;
    end
  end

  // Tag and data arrays are not reset; valid guards them.
  always_ff @(posedge clock) begin
    if (wr_en) begin
      tag_array[wr_index]  <= wr_tag;
      data_array[wr_index] <= wr_data;
    end
  end

  // Lookup: tag compare and word select for the presented address.
  always_comb begin
    rd_match = valid[rd_index] && (tag_array[rd_index] == rd_tag);
    rd_word  = select_word(data_array[rd_index], rd_offset);
  end

endmodule

// File: rtl/icache_controller.sv
// Direct-mapped instruction cache with a blocking miss-fill FSM.
module icache_controller
  import icache_controller_pkg::*;
#(
  parameter int unsigned INDEX_W    = 3,
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned MEM_ADDR_W = 28
) (
  input  logic                clock,
  input  logic                reset_n,
  icache_controller_if.slave  bus,
  output logic [COUNT_W-1:0]  miss_count
);
  localparam int unsigned TAG_LSB = INDEX_LSB + INDEX_W;
  localparam int unsigned TAG_W   = ADDR_W - TAG_LSB;

  state_t state, next_state;

  logic [OFFSET_W-1:0] cpu_offset;
  logic [INDEX_W-1:0]  cpu_index, fill_index;
  logic [TAG_W-1:0]    cpu_tag, fill_tag;
  logic [BLOCK_W-1:0]  fill_data;
  logic [WORD_W-1:0]   store_word;
  logic [COUNT_W-1:0]  count_q;
  logic match, hit, seen_busy, start_fill, fill_done, fill_we;

  assign cpu_offset = bus.cpu_address[OFFSET_LSB +: OFFSET_W];
  assign cpu_index  = bus.cpu_address[INDEX_LSB +: INDEX_W];
  assign cpu_tag    = bus.cpu_address[ADDR_W-1:TAG_LSB];
  assign miss_count = count_q;

  icache_block_store #(
    .INDEX_W (INDEX_W),
    .TAG_W   (TAG_W)
  ) u_store (
    .clock     (clock),
    .reset_n   (reset_n),
    .rd_index  (cpu_index),
    .rd_tag    (cpu_tag),
    .rd_offset (cpu_offset),
    .rd_match  (match),
    .rd_word   (store_word),
    .wr_en     (fill_we),
    .wr_index  (fill_index),
    .wr_tag    (fill_tag),
    .wr_data   (fill_data)
  );

  // State register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= next_state;
  end

  // Next-state: fill runs to completion regardless of what the CPU does.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:     if (start_fill) next_state = MEM_READ;
      MEM_READ: if (fill_done)  next_state = UPDATE;
      UPDATE:   next_state = IDLE;
      default:  next_state = IDLE;
    endcase
  end

  // Outputs: hit only resolves in IDLE; stall is forced low during reset.
  always_comb begin
    hit                 = bus.cpu_read && match && (state == IDLE);
    start_fill          = (state == IDLE) && bus.cpu_read && !match;
    fill_done           = (state == MEM_READ) && seen_busy && !bus.mem_busywait;
    fill_we             = (state == UPDATE);
    bus.cpu_busywait    = reset_n && bus.cpu_read && !hit;
    bus.cpu_instruction = hit ? store_word : '0;
  end

  // Registered memory request, miss latches, busy tracking and fill counter.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      bus.mem_read    <= 1'b0;
      bus.mem_address <= '0;
      fill_index      <= '0;
      fill_tag        <= '0;
      fill_data       <= '0;
      seen_busy       <= 1'b0;
      count_q         <= '0;
    end else begin
      bus.mem_read <= (next_state == MEM_READ);
      if (start_fill) begin
        bus.mem_address <= bus.cpu_address[ADDR_W-1:INDEX_LSB];
        fill_index      <= cpu_index;
        fill_tag        <= cpu_tag;
        seen_busy       <= 1'b0;
      end else if ((state == MEM_READ) && bus.mem_busywait) begin
        seen_busy <= 1'b1;
      end
      if (fill_done) fill_data <= bus.mem_readdata;
      if (fill_we && (count_q != '1)) count_q <= count_q + 1'b1;
    end
  end

endmodule

// File: tb/tb_icache_controller.sv
// Directed bench for icache_controller with a 4-cycle-busy instruction memory.
module tb_icache_controller;
  import icache_controller_pkg::*;

  logic        clock = 1'b0;
  logic        reset_n;
  logic [15:0] miss_count;
  int          checks = 0;
  int          errors = 0;

  icache_controller_if #(.ADDR_W(32), .MEM_ADDR_W(28)) bus ();

  icache_controller #(.INDEX_W(3), .ADDR_W(32), .MEM_ADDR_W(28)) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .bus        (bus),
    .miss_count (miss_count)
  );

  always #5 clock = ~clock;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0) return 32'h08020005;
    if (a == 32'h4) return 32'h080300AD;
    return {16'hC0DE, a[15:0]};
  endfunction

  function automatic logic [127:0] mem_block(input logic [27:0] ba);
    logic [31:0] base;
    base = {ba, 4'b0};
    return {mem_word(base + 12), mem_word(base + 8), mem_word(base + 4), mem_word(base)};
  endfunction

  // Memory model: busy for 4 cycles after mem_read, then data with busy low.
  int mem_cnt = 0;
  always @(negedge clock) begin
    if (!bus.mem_read) begin
      mem_cnt          = 0;
      bus.mem_busywait = 1'b0;
    end else if (mem_cnt < 4) begin
      mem_cnt          = mem_cnt + 1;
      bus.mem_busywait = 1'b1;
    end else begin
      bus.mem_busywait = 1'b0;
      bus.mem_readdata = mem_block(bus.mem_address);
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Waits (bounded) for the stall to clear; returns negedges waited.
  task automatic wait_fill(input string name, output int cycles);
    cycles = 0;
    while (bus.cpu_busywait && cycles < 40) begin
      @(negedge clock); #1;
      cycles++;
    end
    checks++;
    if (bus.cpu_busywait) begin
      errors++;
      $display("FAIL %s: busywait still %b after %0d cycles, expected 0", name, bus.cpu_busywait, cycles);
    end
  endtask

  task automatic wait_mem_read(input string name, input logic level);
    int n = 0;
    while (bus.mem_read !== level && n < 40) begin
      @(negedge clock); #1;
      n++;
    end
    check(name, {31'b0, bus.mem_read}, {31'b0, level});
  endtask

  task automatic drive(input logic rd, input logic [31:0] addr);
    @(negedge clock);
    bus.cpu_read    = rd;
    bus.cpu_address = addr;
    #1;
  endtask

  typedef struct {
    logic        rd;
    logic [31:0] addr;
    logic        exp_busy;
    logic [31:0] exp_instr;
    logic        exp_mem_read;
  } vec_t;

  vec_t vecs[7];
  int   cyc;

  initial begin
    vecs[0] = '{1'b1, 32'h04, 1'b0, 32'h080300AD, 1'b0};
    vecs[1] = '{1'b1, 32'h0C, 1'b0, 32'hC0DE000C, 1'b0};
    vecs[2] = '{1'b1, 32'h08, 1'b0, 32'hC0DE0008, 1'b0};
    vecs[3] = '{1'b1, 32'h00, 1'b0, 32'h08020005, 1'b0};
    vecs[4] = '{1'b1, 32'h06, 1'b0, 32'h080300AD, 1'b0};
    vecs[5] = '{1'b0, 32'h40, 1'b0, 32'h00000000, 1'b0};
    vecs[6] = '{1'b0, 32'h80, 1'b0, 32'h00000000, 1'b0};

    reset_n          = 1'b0;
    bus.cpu_read     = 1'b1;
    bus.cpu_address  = 32'h0;
    bus.mem_busywait = 1'b0;
    bus.mem_readdata = '0;

    // Reset state, with a pending read held off.
    @(negedge clock); #1;
    check("rst_busywait", {31'b0, bus.cpu_busywait}, 32'h0);
    check("rst_instr", bus.cpu_instruction, 32'h0);
    check("rst_mem_read", {31'b0, bus.mem_read}, 32'h0);
    check("rst_mem_address", {4'b0, bus.mem_address}, 32'h0);
    check("rst_miss_count", {16'b0, miss_count}, 32'h0);

    // 1: cold miss at 0x00 with full-latency check.
    @(negedge clock);
    reset_n = 1'b1;
    #1;
    check("t1_busywait", {31'b0, bus.cpu_busywait}, 32'h1);
    check("t1_mem_read_pre", {31'b0, bus.mem_read}, 32'h0);
    @(negedge clock); #1;
    check("t1_mem_read", {31'b0, bus.mem_read}, 32'h1);
    check("t1_mem_address", {4'b0, bus.mem_address}, 32'h0);
    wait_fill("t1_fill", cyc);
    check("t1_latency", cyc + 1, 32'd7);
    check("t1_instr", bus.cpu_instruction, 32'h08020005);
    check("t1_miss_count", {16'b0, miss_count}, 32'h1);

    // 2 and 5a: hits and idle cycles from the table.
    for (int i = 0; i < 7; i++) begin
      drive(vecs[i].rd, vecs[i].addr);
      @(negedge clock); #1;
      check($sformatf("vec%0d_busywait", i), {31'b0, bus.cpu_busywait}, {31'b0, vecs[i].exp_busy});
      check($sformatf("vec%0d_instr", i), bus.cpu_instruction, vecs[i].exp_instr);
      check($sformatf("vec%0d_mem_read", i), {31'b0, bus.mem_read}, {31'b0, vecs[i].exp_mem_read});
    end
    check("t2_miss_count", {16'b0, miss_count}, 32'h1);

    // 3: conflict miss evicts set 0, then 0x00 misses again.
    drive(1'b1, 32'h80);
    check("t3_busywait", {31'b0, bus.cpu_busywait}, 32'h1);
    @(negedge clock); #1;
    check("t3_mem_address_80", {4'b0, bus.mem_address}, 32'h8);
    wait_fill("t3_fill_80", cyc);
    check("t3_instr_80", bus.cpu_instruction, 32'hC0DE0080);
    drive(1'b1, 32'h00);
    check("t3_remiss", {31'b0, bus.cpu_busywait}, 32'h1);
    @(negedge clock); #1;
    check("t3_mem_address_00", {4'b0, bus.mem_address}, 32'h0);
    wait_fill("t3_fill_00", cyc);
    check("t3_instr_00", bus.cpu_instruction, 32'h08020005);
    check("t3_miss_count", {16'b0, miss_count}, 32'h3);

    // 5b: PC moves mid-fill; line 0 still installs, then 0x10 misses.
    drive(1'b1, 32'h80);
    wait_fill("t5_fill_80", cyc);
    drive(1'b1, 32'h00);
    @(negedge clock); #1;
    check("t5_mem_address_00", {4'b0, bus.mem_address}, 32'h0);
    bus.cpu_address = 32'h10;
    wait_mem_read("t5_fill0_end", 1'b0);
    wait_mem_read("t5_fill1_start", 1'b1);
    check("t5_mem_address_10", {4'b0, bus.mem_address}, 32'h1);
    wait_fill("t5_fill_10", cyc);
    check("t5_instr_10", bus.cpu_instruction, 32'hC0DE0010);
    drive(1'b1, 32'h00);
    check("t5_line0_hit", {31'b0, bus.cpu_busywait}, 32'h0);
    check("t5_line0_instr", bus.cpu_instruction, 32'h08020005);
    check("t5_miss_count", {16'b0, miss_count}, 32'h6);

    // 4: reset during MEM_READ drops mem_read and clears valid.
    drive(1'b1, 32'h20);
    @(negedge clock); #1;
    check("t4_mem_read_on", {31'b0, bus.mem_read}, 32'h1);
    reset_n = 1'b0;
    #1;
    check("t4_mem_read_off", {31'b0, bus.mem_read}, 32'h0);
    check("t4_busywait", {31'b0, bus.cpu_busywait}, 32'h0);
    check("t4_miss_count", {16'b0, miss_count}, 32'h0);
    @(negedge clock);
    reset_n         = 1'b1;
    bus.cpu_address = 32'h0;
    #1;
    check("t4_valid_cleared", {31'b0, bus.cpu_busywait}, 32'h1);
    wait_fill("t4_fill", cyc);
    check("t4_instr", bus.cpu_instruction, 32'h08020005);
    check("t4_miss_count_after", {16'b0, miss_count}, 32'h1);

    // 6: counter saturation.
    @(negedge clock);
    force dut.count_q = 16'hFFFE;
    #1;
    release dut.count_q;
    check("t6_preload", {16'b0, miss_count}, 32'hFFFE);
    drive(1'b1, 32'h30);
    wait_fill("t6_fill_30", cyc);
    check("t6_count_max", {16'b0, miss_count}, 32'hFFFF);
    drive(1'b1, 32'h40);
    wait_fill("t6_fill_40", cyc);
    check("t6_count_sat", {16'b0, miss_count}, 32'hFFFF);
    check("t6_instr_40", bus.cpu_instruction, 32'hC0DE0040);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
